// File: rtl/bin2bcd_seq_7seg.sv
// Clocked double-dabble binary-to-BCD converter driving active-low seven-segment fields.
// Define BIN2BCD_SEQ_7SEG_BLANK_EN to blank leading zero digits (unless the result overflowed).
module bin2bcd_seq_7seg #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int              CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_reg, state_next;
   logic [WIDTH-1:0]     shift_reg, shift_next;
   logic [4*DIGITS-1:0]  work_reg, work_next;
   logic [4*DIGITS-1:0]  work_adj, work_shift;
   logic                 acc_reg, acc_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [4*DIGITS-1:0]  bcd_reg, bcd_next;
   logic                 ovf_reg, ovf_next;
   logic                 done_reg, done_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Add-3 correction applied to every working digit before the shift.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                      work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
      end
   endgenerate

   // The top adjusted bit is dropped here and folded into the overflow accumulator instead.
   assign work_shift = {work_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         work_reg  <= '0;
         acc_reg   <= 1'b0;
         cnt_reg   <= '0;
         bcd_reg   <= '0;
         ovf_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         work_reg  <= work_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         bcd_reg   <= bcd_next;
         ovf_reg   <= ovf_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      work_next  = work_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      bcd_next   = bcd_reg;
      ovf_next   = ovf_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               shift_next = bin;
               work_next  = '0;
               acc_next   = 1'b0;
               cnt_next   = CNT_INIT;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_next = shift_reg << 1;
            work_next  = work_shift;
            acc_next   = acc_reg | work_adj[4*DIGITS-1];
            cnt_next   = cnt_reg - CNT_LAST;
            if (cnt_reg == CNT_LAST) begin
               bcd_next   = work_shift;
               ovf_next   = acc_next;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg == SHIFT);
   assign done = done_reg;
   assign ovf  = ovf_reg;
   assign bcd  = bcd_reg;

   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_hex
         logic blank;
`ifdef BIN2BCD_SEQ_7SEG_BLANK_EN
         if (gi > 0) begin : g_lead
            // Blank when this digit and all higher digits are zero.
            assign blank = (bcd_reg[4*DIGITS-1:4*gi] == '0) && !ovf_reg;
         end else begin : g_units
            assign blank = 1'b0;
         end
`else
         assign blank = 1'b0;
`endif
         assign hex[7*gi +: 7] = blank ? 7'h7F : seg_decode(bcd_reg[4*gi +: 4]);
      end
   endgenerate

endmodule

// File: tb/tb_bin2bcd_seq_7seg.sv
// Directed scoreboard bench for bin2bcd_seq_7seg: a 3-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_seq_7seg;

   localparam int W = 8;
`ifdef BIN2BCD_SEQ_7SEG_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   typedef struct packed {
      logic [11:0] bcd;
      logic        ovf;
      logic [20:0] hex;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  bin;
   logic        busy3, done3, ovf3;
   logic [11:0] bcd3;
   logic [20:0] hex3;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;
   logic [13:0] hex2;

   int   checks = 0;
   int   errors = 0;
   res_t q3[$];
   res_t q2[$];
   res_t last3, last2;

   always #5 clk = ~clk;

   bin2bcd_seq_7seg #(.WIDTH(W), .DIGITS(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .busy(busy3), .done(done3), .ovf(ovf3), .bcd(bcd3), .hex(hex3)
   );

   bin2bcd_seq_7seg #(.WIDTH(W), .DIGITS(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .hex(hex2)
   );

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic res_t model(input int v, input int nd);
      res_t r;
      int   d[3];
      int   p;
      bit   lz;
      r = '0;
      p = 1;
      for (int k = 0; k < 3; k++) d[k] = 0;
      for (int k = 0; k < nd; k++) begin
         d[k] = (v / p) % 10;
         p = p * 10;
      end
      r.ovf = (v >= p);
      lz = 1'b1;
      for (int k = nd - 1; k >= 0; k--) begin
         r.bcd[4*k +: 4] = 4'(d[k]);
         lz = lz && (d[k] == 0);
         r.hex[7*k +: 7] = (BLANK && k > 0 && lz && !r.ovf) ? 7'h7F : glyph(d[k]);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int junk, input logic hold, input logic [7:0] bin_after,
                            output int n, output int bc);
      n  = 0;
      bc = 0;
      while (done3 !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (busy3 === 1'b1) bc++;
         if (n == 1) begin start = hold; bin = bin_after; end
         if (junk >= 0 && n == 3) begin start = 1'b1; bin = 8'(junk); end
         if (junk >= 0 && n == 4) begin start = hold; bin = bin_after; end
      end
      checks++;
      assert (done3 === 1'b1 && done2 === 1'b1) else begin
         errors++;
         $error("FAIL done_wait observed=%0b%0b expected=11 after %0d cycles", done3, done2, n);
      end
   endtask

   task automatic pop_check(input int v);
      if (q3.size() == 0 || q2.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=%0d expected=1", q3.size());
      end else begin
         last3 = q3.pop_front();
         last2 = q2.pop_front();
         $display("txn bin=%0d bcd3=%03h ovf3=%0b hex3=%06h bcd2=%02h ovf2=%0b hex2=%04h",
                  v, bcd3, ovf3, hex3, bcd2, ovf2, hex2);
         chk("bcd3", 32'(bcd3), 32'(last3.bcd));
         chk("ovf3", 32'(ovf3), 32'(last3.ovf));
         chk("hex3", 32'(hex3), 32'(last3.hex));
         chk("bcd2", 32'(bcd2), 32'(last2.bcd[7:0]));
         chk("ovf2", 32'(ovf2), 32'(last2.ovf));
         chk("hex2", 32'(hex2), 32'(last2.hex[13:0]));
      end
   endtask

   task automatic run(input int v, input int junk);
      int n, bc;
      start = 1'b1;
      bin   = 8'(v);
      q3.push_back(model(v, 3));
      q2.push_back(model(v, 2));
      wait_done(junk, 1'b0, 8'(v), n, bc);
      chk("latency", 32'(n), 32'(W + 1));
      chk("busy_cycles", 32'(bc), 32'(W));
      chk("busy_in_done", 32'(busy3), 32'd0);
      pop_check(v);
      @(negedge clk);
      chk("done_one_cycle", 32'({done3, done2}), 32'd0);
      chk("idle_after_done", 32'({busy3, busy2}), 32'd0);
      chk("bcd3_hold", 32'(bcd3), 32'(last3.bcd));
   endtask

   initial begin
      int   n, bc, n2, seen;
      res_t z3, z2;
      z3 = model(0, 3);
      z2 = model(0, 2);
      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'({busy3, busy2}), 32'd0);
      chk("rst_done", 32'({done3, done2}), 32'd0);
      chk("rst_ovf", 32'({ovf3, ovf2}), 32'd0);
      chk("rst_bcd3", 32'(bcd3), 32'd0);
      chk("rst_hex3", 32'(hex3), 32'(z3.hex));
      chk("rst_hex2", 32'(hex2), 32'(z2.hex[13:0]));
      reset = 1'b0;
      @(negedge clk);

      run(255, -1);
      run(0, -1);
      run(7, -1);
      run(200, -1);
      run(99, 55);
      run(1, -1);
      run(128, -1);

      // start held high: 10 then 20 back to back
      start = 1'b1;
      bin   = 8'd10;
      q3.push_back(model(10, 3));
      q2.push_back(model(10, 2));
      q3.push_back(model(20, 3));
      q2.push_back(model(20, 2));
      wait_done(-1, 1'b1, 8'd20, n, bc);
      chk("held_latency", 32'(n), 32'(W + 1));
      pop_check(10);
      @(negedge clk);
      chk("held_reaccept", 32'(busy3), 32'd1);
      wait_done(-1, 1'b1, 8'd20, n2, bc);
      start = 1'b0;
      chk("done_period", 32'(n2 + 1), 32'(W + 1));
      pop_check(20);
      @(negedge clk);
      chk("held_release_idle", 32'(busy3), 32'd0);

      // reset three cycles into a conversion
      start = 1'b1;
      bin   = 8'd255;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'({busy3, busy2}), 32'd0);
      chk("mid_rst_done", 32'({done3, done2}), 32'd0);
      chk("mid_rst_bcd3", 32'(bcd3), 32'd0);
      chk("mid_rst_bcd2", 32'(bcd2), 32'd0);
      chk("mid_rst_ovf", 32'({ovf3, ovf2}), 32'd0);
      chk("mid_rst_hex3", 32'(hex3), 32'(z3.hex));
      @(negedge clk);
      reset = 1'b0;
      seen  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done3 === 1'b1 || done2 === 1'b1 || busy3 === 1'b1) seen++;
      end
      chk("no_done_after_reset", 32'(seen), 32'd0);

      run(42, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
